// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter. The CPU pushes bytes into a small TX
//   FIFO through the TXDATA register. A serialiser drains the FIFO at a
//   programmable number of clocks per bit.
//
//   Register map (addr_i[3:2] selects, addr_i[1:0] ignored):
//     0x0 TXDATA  (W)    push wdata_i[7:0]; reads 0
//     0x4 STATUS  (R/W1C) {overflow, busy, empty, full}; write 1 to bit3 clears
//     0x8 DIVISOR (R/W)  clocks per bit in [15:0], values < 2 stored as 2
//     0xC         reads 0, writes ignored
//
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     we_i, re_i         bus write / read strobes (both honoured together)
//     addr_i, wdata_i    bus address and write data
//     rdata_o            registered read data, valid the cycle after re_i
//     tx_o               serial line, idle high
//     busy_o             high while a frame is on the line
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [15:0]        timer_q, timer_d;
    logic [15:0]        act_div_q, act_div_d;
    logic [15:0]        div_q;
    logic               overflow_q;
    logic [31:0]        rdata_q;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [1:0]         reg_sel;
    logic               fifo_full, fifo_empty;
    logic               push_req, push, pop;
    logic               bit_done;

    // Address low bits and upper write-data bits carry no meaning here.
    logic               unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

    assign reg_sel    = addr_i[3:2];
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop does not
    // make room for a push that arrives while full.
    assign push_req   = we_i && (reg_sel == REG_TXDATA);
    assign push       = push_req && !fifo_full;
    assign bit_done   = (timer_q == '0);

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so reset alone discards the contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    // ----------------------------------------------------- serialiser FSM
    // NOTE: every combinational output gets a default before the case so
    // that no path leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        timer_d   = timer_q;
        act_div_d = act_div_q;
        pop       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d   = ST_START;
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    act_div_d = div_q;
                    timer_d   = div_q - 16'd1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    timer_d   = act_div_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d = act_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        // Back-to-back frame: skip IDLE so no gap appears.
                        state_d   = ST_START;
                        pop       = 1'b1;
                        shift_d   = fifo_mem[rd_ptr_q];
                        act_div_d = div_q;
                        timer_d   = div_q - 16'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level decoded from state so reset drives it high immediately.
    always_comb begin
        tx_o = 1'b1;
        if (state_q == ST_START) begin
            tx_o = 1'b0;
        end else if (state_q == ST_DATA) begin
            tx_o = shift_q[0];
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign rdata_o = rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            act_div_q  <= 16'(DEFAULT_DIV);
            div_q      <= 16'(DEFAULT_DIV);
            overflow_q <= 1'b0;
            rdata_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            timer_q   <= timer_d;
            act_div_q <= act_div_d;
            count_q   <= count_d;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (we_i && (reg_sel == REG_STATUS) && wdata_i[3]) begin
                overflow_q <= 1'b0;
            end

            if (we_i && (reg_sel == REG_DIVISOR)) begin
                div_q <= (wdata_i[15:0] < 16'd2) ? 16'd2 : wdata_i[15:0];
            end

            if (re_i) begin
                unique case (reg_sel)
                    REG_STATUS:  rdata_q <= {28'd0, overflow_q, busy_o, fifo_empty, fifo_full};
                    REG_DIVISOR: rdata_q <= {16'd0, div_q};
                    default:     rdata_q <= '0;
                endcase
            end
        end
    end

endmodule
